// File: rtl/bfcpu_pkg.sv
// bfcpu_pkg: definitions shared by the bfcpu instruction-fetch blocks.
//   BFCPU_ADDR_WIDTH  - default instruction address width
//   BFCPU_IMEM_LENGTH - default instruction memory length in bytes
//   fetch_state_e     - fetch FSM states (IDLE / REQ / GAP)
package bfcpu_pkg;

    localparam int BFCPU_ADDR_WIDTH  = 16;
    localparam int BFCPU_IMEM_LENGTH = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/i_fetch_fifo.sv
// i_fetch_fifo: synchronous first-word-fall-through FIFO.
// DEPTH must be a power of two and at least 2.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push_i       - write push_data_i (ignored when full or flushing)
//   push_data_i  - write data
//   pop_i        - drop the head entry (ignored when empty or flushing)
//   flush_i      - empty the FIFO at the clock edge; overrides push/pop
//   head_o       - head entry, valid whenever empty_o is low
//   count_o      - number of stored entries
//   empty_o      - no entries stored
//   full_o       - DEPTH entries stored
module i_fetch_fifo
    import bfcpu_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/i_fetch_icecream_v1.sv
// i_fetch_icecream_v1: instruction-fetch initiator for the bfcpu core.
// Issues one request/ack read per byte, prefetches sequential opcode bytes
// into a FWFT FIFO and hands them to the decoder over valid/ready.
// Redirects flush the FIFO and restart fetch at a new address.
// Optional feature macro: BFCPU_IFETCH_PERF_EN adds output fetch_count.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   redir_valid/addr      - one-cycle redirect to a new fetch address
//   ins_valid/data/addr   - head instruction byte and its address
//   ins_ready             - decoder consumes head on valid && ready
//   end_of_mem            - fetch reached i_mem_length, FIFO empty, idle
//   i_req/i_addr          - memory request (held until ack)
//   i_ack/i_rdata         - memory acknowledge and read data
//   fetch_count           - accepted acks, saturating (macro only)
module i_fetch_icecream_v1
    import bfcpu_pkg::*;
#(
    parameter int i_addr_width = BFCPU_ADDR_WIDTH,
    parameter int i_mem_length = BFCPU_IMEM_LENGTH,
    parameter int fifo_depth   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redir_valid,
    input  logic [i_addr_width-1:0] redir_addr,
    output logic                    ins_valid,
    output logic [7:0]              ins_data,
    output logic [i_addr_width-1:0] ins_addr,
    input  logic                    ins_ready,
    output logic                    end_of_mem,
    output logic                    i_req,
    output logic [i_addr_width-1:0] i_addr,
    input  logic                    i_ack,
    input  logic [7:0]              i_rdata
`ifdef BFCPU_IFETCH_PERF_EN
   ,output logic [31:0]             fetch_count
`endif
);

    localparam int AW = i_addr_width;
    localparam int PW = i_addr_width + 1;
    localparam int CW = $clog2(fifo_depth) + 1;
    localparam logic [PW-1:0] MEM_LEN = PW'(i_mem_length);
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(fifo_depth);

    fetch_state_e    state_q, state_d;
    logic [PW-1:0]   fetch_pc_q, fetch_pc_d;
    logic            i_req_q, i_req_d;
    logic [AW-1:0]   i_addr_q, i_addr_d;
    logic            stale_q, stale_d;

    logic            push;
    logic            ack_take;
    logic            can_issue;
    logic [CW:0]     in_flight;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full;
    logic [AW+7:0]   fifo_head;

    assign ack_take  = (state_q == REQ) && i_ack;
    // The outstanding request already owns a FIFO slot, so a push can never overflow.
    assign in_flight = {1'b0, fifo_count} + (CW + 1)'(state_q == REQ);
    // No issue in a redirect cycle: it would fetch from the address being abandoned.
    assign can_issue = !fifo_full && (in_flight < DEPTH_L) &&
                       (fetch_pc_q < MEM_LEN) && !redir_valid;
    assign push      = ack_take && !stale_q && !redir_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        i_req_d    = i_req_q;
        i_addr_d   = i_addr_q;
        stale_d    = stale_q;
        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d  = REQ;
                    i_req_d  = 1'b1;
                    i_addr_d = fetch_pc_q[AW-1:0];
                end
            end
            REQ: begin
                if (redir_valid) stale_d = 1'b1;
                if (i_ack) begin
                    // A stale ack leaves fetch_pc at the redirect target.
                    if (!stale_q && !redir_valid) fetch_pc_d = fetch_pc_q + PW'(1);
                    i_req_d = 1'b0;
                    stale_d = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (redir_valid) fetch_pc_d = {1'b0, redir_addr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            i_req_q    <= 1'b0;
            i_addr_q   <= '0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            i_req_q    <= i_req_d;
            i_addr_q   <= i_addr_d;
            stale_q    <= stale_d;
        end
    end

    i_fetch_fifo #(
        .WIDTH (AW + 8),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({i_addr_q, i_rdata}),
        .pop_i       (ins_valid && ins_ready),
        .flush_i     (redir_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign i_req      = i_req_q;
    assign i_addr     = i_addr_q;
    assign ins_valid  = !fifo_empty;
    assign ins_addr   = fifo_head[AW+7:8];
    assign ins_data   = fifo_head[7:0];
    assign end_of_mem = (fetch_pc_q >= MEM_LEN) && fifo_empty && (state_q == IDLE);

`ifdef BFCPU_IFETCH_PERF_EN
    logic [31:0] fetch_count_q;

    // Counts every accepted ack, stale ones included, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
        end else if (ack_take && (fetch_count_q != '1)) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule
